// File: rtl/clock_cfg_pkg.sv
// Shared types for the clock configuration sequencer: FSM states, the packed
// clock-routing configuration word and its reset value.
package clock_cfg_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_BYP = 2'd1,
        HOLD_DIV = 2'd2,
        HOLD_SW  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       src;
        logic [2:0] sel;
        logic [2:0] sel2;
        logic [7:0] auxdiv;
        logic [7:0] primdiv;
    } clk_cfg_t;

    localparam clk_cfg_t CFG_RESET = '{
        src:     1'b1,
        sel:     3'd0,
        sel2:    3'd0,
        auxdiv:  8'd0,
        primdiv: 8'd0
    };

    function automatic logic dividers_differ(input clk_cfg_t a, input clk_cfg_t b);
        return (a.sel != b.sel) || (a.sel2 != b.sel2) ||
               (a.auxdiv != b.auxdiv) || (a.primdiv != b.primdiv);
    endfunction

    // Takes the dividers from nxt while keeping the source currently in use.
    function automatic clk_cfg_t with_dividers(input clk_cfg_t cur, input clk_cfg_t nxt);
        clk_cfg_t r;
        r     = nxt;
        r.src = cur.src;
        return r;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter shared by every hold state of the sequencer; zero
// marks the end of a settle interval.
module settle_timer
    import clock_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             resetb,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Decrement saturates so a stray dec at zero can never wrap to 255.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/clock_config_sequencer.sv
// Glitch-safe clock-routing update: park on ext_clk, change dividers, restore source.
// Optional macro DLL_LOCK_CHECK_EN adds dll_lock / lock_err source-restore gating.
module clock_config_sequencer
    import clock_cfg_pkg::*;
#(
    parameter int SETTLE = 16
) (
    input  logic       ext_clk,
    input  logic       resetb,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       cfg_ext_clk_sel,
    input  logic [2:0] cfg_sel,
    input  logic [2:0] cfg_sel2,
    input  logic [7:0] cfg_auxdiv,
    input  logic [7:0] cfg_primdiv,
`ifdef DLL_LOCK_CHECK_EN
    input  logic       dll_lock,
    output logic       lock_err,
`endif
    output logic       ext_clk_sel,
    output logic [2:0] sel,
    output logic [2:0] sel2,
    output logic [7:0] auxdiv,
    output logic [7:0] primdiv,
    output logic       done,
    output logic       busy
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

    seq_state_t state_d, state_q;
    clk_cfg_t   cfg_in;
    clk_cfg_t   shadow_d, shadow_q;
    clk_cfg_t   out_d, out_q;
    logic       done_d, done_q;
    logic       tmr_load, tmr_dec, tmr_zero;
`ifdef DLL_LOCK_CHECK_EN
    logic       lock_err_d, lock_err_q;
`endif

    assign cfg_in = '{
        src:     cfg_ext_clk_sel,
        sel:     cfg_sel,
        sel2:    cfg_sel2,
        auxdiv:  cfg_auxdiv,
        primdiv: cfg_primdiv
    };

    settle_timer u_settle_timer (
        .clk      (ext_clk),
        .resetb   (resetb),
        .load     (tmr_load),
        .load_val (RELOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
`ifdef DLL_LOCK_CHECK_EN
        lock_err_d = lock_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    shadow_d = cfg_in;
                    tmr_load = 1'b1;
`ifdef DLL_LOCK_CHECK_EN
                    lock_err_d = 1'b0;
`endif
                    // Divider changes need the bypass detour; a pure source switch does not.
                    if (dividers_differ(cfg_in, out_q)) begin
                        out_d.src = 1'b1;
                        state_d   = HOLD_BYP;
                    end else begin
                        out_d.src = cfg_in.src;
                        state_d   = HOLD_SW;
                    end
                end
            end
            HOLD_BYP: begin
                if (tmr_zero) begin
                    out_d    = with_dividers(out_q, shadow_q);
                    tmr_load = 1'b1;
                    state_d  = HOLD_DIV;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            HOLD_DIV: begin
                if (tmr_zero) begin
`ifdef DLL_LOCK_CHECK_EN
                    // An unlocked DLL is never selected; stay parked and flag it.
                    if (!shadow_q.src && !dll_lock) begin
                        out_d.src  = 1'b1;
                        lock_err_d = 1'b1;
                    end else begin
                        out_d.src = shadow_q.src;
                    end
`else
                    out_d.src = shadow_q.src;
`endif
                    tmr_load = 1'b1;
                    state_d  = HOLD_SW;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            HOLD_SW: begin
                if (tmr_zero) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ext_clk) begin
        if (!resetb) begin
            state_q  <= IDLE;
            shadow_q <= CFG_RESET;
            out_q    <= CFG_RESET;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            done_q   <= done_d;
        end
    end

`ifdef DLL_LOCK_CHECK_EN
    always_ff @(posedge ext_clk) begin
        if (!resetb) begin
            lock_err_q <= 1'b0;
        end else begin
            lock_err_q <= lock_err_d;
        end
    end

    assign lock_err = lock_err_q;
`endif

    assign ext_clk_sel = out_q.src;
    assign sel         = out_q.sel;
    assign sel2        = out_q.sel2;
    assign auxdiv      = out_q.auxdiv;
    assign primdiv     = out_q.primdiv;
    assign done        = done_q;
    assign req_ready   = (state_q == IDLE);
    assign busy        = ~req_ready;

endmodule

// File: tb/tb_clock_config_sequencer.sv
// Self-checking bench: timestamp-based reference model compared every cycle,
// plus directed literal checks (SETTLE=4 main instance, SETTLE=1 boundary instance).
module tb_clock_config_sequencer;

    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetb;
    logic       req_valid, req_valid1;
    logic       cfg_src;
    logic [2:0] cfg_sel, cfg_sel2;
    logic [7:0] cfg_aux, cfg_prim;

    logic       ready, busy, done, ext_sel;
    logic [2:0] sel, sel2;
    logic [7:0] aux, prim;
    logic       ready1, busy1, done1, ext_sel1;
    logic [2:0] sel_1, sel2_1;
    logic [7:0] aux1, prim1;
`ifdef DLL_LOCK_CHECK_EN
    logic       dll_lock, lock_err, lock_err1;
`endif

    int total = 0;
    int bad   = 0;

    clock_config_sequencer #(.SETTLE(S)) u_dut (
        .ext_clk(clk), .resetb(resetb), .req_valid(req_valid), .req_ready(ready),
        .cfg_ext_clk_sel(cfg_src), .cfg_sel(cfg_sel), .cfg_sel2(cfg_sel2),
        .cfg_auxdiv(cfg_aux), .cfg_primdiv(cfg_prim),
`ifdef DLL_LOCK_CHECK_EN
        .dll_lock(dll_lock), .lock_err(lock_err),
`endif
        .ext_clk_sel(ext_sel), .sel(sel), .sel2(sel2), .auxdiv(aux), .primdiv(prim),
        .done(done), .busy(busy)
    );

    clock_config_sequencer #(.SETTLE(1)) u_dut1 (
        .ext_clk(clk), .resetb(resetb), .req_valid(req_valid1), .req_ready(ready1),
        .cfg_ext_clk_sel(cfg_src), .cfg_sel(cfg_sel), .cfg_sel2(cfg_sel2),
        .cfg_auxdiv(cfg_aux), .cfg_primdiv(cfg_prim),
`ifdef DLL_LOCK_CHECK_EN
        .dll_lock(dll_lock), .lock_err(lock_err1),
`endif
        .ext_clk_sel(ext_sel1), .sel(sel_1), .sel2(sel2_1), .auxdiv(aux1), .primdiv(prim1),
        .done(done1), .busy(busy1)
    );

    // Reference model: outputs derived from the number of edges since acceptance.
    logic       m_src;
    logic [2:0] m_sel, m_sel2;
    logic [7:0] m_aux, m_prim;
    logic       s_src;
    logic [2:0] s_sel, s_sel2;
    logic [7:0] s_aux, s_prim;
    logic       m_done, m_busy, m_full, m_lock_err;
    int         edge_n = 0;
    int         m_t0   = 0;
    bit         cmp_en = 1'b0;

    always @(posedge clk) begin : model
        int e;
        edge_n++;
        m_done = 1'b0;
        if (!resetb) begin
            m_src = 1'b1; m_sel = 3'd0; m_sel2 = 3'd0; m_aux = 8'd0; m_prim = 8'd0;
            m_busy = 1'b0; m_lock_err = 1'b0;
        end else if (m_busy) begin
            e = edge_n - m_t0;
            if (m_full) begin
                if (e == S) begin
                    m_sel = s_sel; m_sel2 = s_sel2; m_aux = s_aux; m_prim = s_prim;
                end else if (e == 2 * S) begin
                    m_src = s_src;
`ifdef DLL_LOCK_CHECK_EN
                    if (!s_src && !dll_lock) begin
                        m_src = 1'b1;
                        m_lock_err = 1'b1;
                    end
`endif
                end else if (e == 3 * S) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (e == S) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end else if (req_valid) begin
            m_t0 = edge_n;
            s_src = cfg_src; s_sel = cfg_sel; s_sel2 = cfg_sel2; s_aux = cfg_aux; s_prim = cfg_prim;
            m_full = (s_sel != m_sel) || (s_sel2 != m_sel2) || (s_aux != m_aux) || (s_prim != m_prim);
            m_src = m_full ? 1'b1 : s_src;
            m_busy = 1'b1;
            m_lock_err = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic src, input logic [2:0] s,
                                 input logic [2:0] s2, input logic [7:0] a, input logic [7:0] p);
        req_valid = v;
        cfg_src   = src;
        cfg_sel   = s;
        cfg_sel2  = s2;
        cfg_aux   = a;
        cfg_prim  = p;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model_ctrl", 32'({ext_sel, sel, sel2, aux, prim}),
                        32'({m_src, m_sel, m_sel2, m_aux, m_prim}));
            checkOutput("model_done", 32'(done), 32'(m_done));
            checkOutput("model_ready", 32'(ready), 32'(!m_busy));
            checkOutput("model_busy", 32'(busy), 32'(m_busy));
`ifdef DLL_LOCK_CHECK_EN
            checkOutput("model_lock_err", 32'(lock_err), 32'(m_lock_err));
`endif
        end
    end

    initial begin
        resetb = 1'b0;
        req_valid1 = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0);
`ifdef DLL_LOCK_CHECK_EN
        dll_lock = 1'b1;
`endif
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        checkOutput("rst_ext_sel", 32'(ext_sel), 1);
        checkOutput("rst_dividers", 32'({sel, sel2, aux, prim}), 0);
        checkOutput("rst_ready", 32'(ready), 1);
        checkOutput("rst_done", 32'(done), 0);
        resetb = 1'b1;

        // SETTLE=1 boundary: one cycle per step
        applyStimulus(1'b0, 1'b0, 3'd5, 3'd0, 8'd0, 8'd0);
        req_valid1 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b0;
        checkOutput("s1_park", 32'({ext_sel1, sel_1}), 32'({1'b1, 3'd0}));
        checkOutput("s1_busy", 32'(busy1), 1);
        @(negedge clk);
        checkOutput("s1_divs", 32'({ext_sel1, sel_1}), 32'({1'b1, 3'd5}));
        @(negedge clk);
        checkOutput("s1_restore", 32'(ext_sel1), 0);
        checkOutput("s1_done_early", 32'(done1), 0);
        @(negedge clk);
        checkOutput("s1_done", 32'({done1, ready1}), 32'(2'b11));
`ifdef DLL_LOCK_CHECK_EN
        checkOutput("s1_lock_err", 32'(lock_err1), 0);
`endif
        @(negedge clk);
        checkOutput("s1_done_pulse", 32'(done1), 0);

        // Full sequence, SETTLE=4
        applyStimulus(1'b1, 1'b0, 3'd2, 3'd1, 8'd4, 8'd8);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("full_park", 32'({ext_sel, sel}), 32'({1'b1, 3'd0}));
        repeat (3) @(negedge clk);
        checkOutput("full_divs_hold", 32'({sel, sel2, aux, prim}), 0);
        @(negedge clk);
        checkOutput("full_divs", 32'({ext_sel, sel, sel2, aux, prim}), 32'({1'b1, 3'd2, 3'd1, 8'd4, 8'd8}));
        repeat (3) @(negedge clk);
        checkOutput("full_parked_still", 32'(ext_sel), 1);
        @(negedge clk);
        checkOutput("full_restore", 32'(ext_sel), 0);
        repeat (3) @(negedge clk);
        checkOutput("full_done_early", 32'(done), 0);
        @(negedge clk);
        checkOutput("full_done", 32'({done, ready}), 32'(2'b11));
        @(negedge clk);
        checkOutput("full_done_pulse", 32'(done), 0);

        // Source-only 0->1, then 1->0 accepted in the done cycle
        applyStimulus(1'b1, 1'b1, 3'd2, 3'd1, 8'd4, 8'd8);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("src_only_up", 32'({ext_sel, sel}), 32'({1'b1, 3'd2}));
        repeat (S) @(negedge clk);
        checkOutput("src_only_up_done", 32'(done), 1);
        applyStimulus(1'b1, 1'b0, 3'd2, 3'd1, 8'd4, 8'd8);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("src_only_dn", 32'({ext_sel, sel, aux}), 32'({1'b0, 3'd2, 8'd4}));
        repeat (S - 1) @(negedge clk);
        checkOutput("src_only_dn_early", 32'(done), 0);
        @(negedge clk);
        checkOutput("src_only_dn_done", 32'({done, sel, prim}), 32'({1'b1, 3'd2, 8'd8}));

        // Held req_valid: cfg churn while busy is ignored, second accepted in done cycle
        applyStimulus(1'b1, 1'b0, 3'd7, 3'd3, 8'h55, 8'haa);
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            applyStimulus(1'b1, 1'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
        end
        applyStimulus(1'b1, 1'b1, 3'd1, 3'd2, 8'd3, 8'd4);
        @(negedge clk);
        checkOutput("held_done", 32'({done, ready}), 32'(2'b11));
        checkOutput("held_first_cfg", 32'({ext_sel, sel, aux}), 32'({1'b0, 3'd7, 8'h55}));
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("held_second_accept", 32'({busy, done, ext_sel}), 32'(3'b101));
        repeat (12) @(negedge clk);
        checkOutput("held_second_done", 32'({done, ext_sel, sel, aux}), 32'({1'b1, 1'b1, 3'd1, 8'd3}));
        @(negedge clk);

        // Reset during HOLD_DIV
        applyStimulus(1'b1, 1'b0, 3'd4, 3'd5, 8'd9, 8'd10);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rst_mid_divs", 32'(sel), 4);
        resetb = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        checkOutput("rst_mid_ctrl", 32'({ext_sel, sel, sel2, aux, prim}), 32'({1'b1, 22'd0}));
        checkOutput("rst_mid_flags", 32'({ready, done}), 32'(2'b10));
        repeat (3 * S + 2) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 3'd4, 3'd5, 8'd9, 8'd10);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rst_rerun_park", 32'({ext_sel, sel}), 32'({1'b1, 3'd0}));
        repeat (3 * S) @(negedge clk);
        checkOutput("rst_rerun_done", 32'({done, ext_sel, sel}), 32'({1'b1, 1'b0, 3'd4}));
        @(negedge clk);

`ifdef DLL_LOCK_CHECK_EN
        dll_lock = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'd6, 3'd5, 8'd9, 8'd10);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3 * S) @(negedge clk);
        checkOutput("lock_fail", 32'({done, ext_sel, lock_err, sel}), 32'({3'b111, 3'd6}));
        @(negedge clk);
        dll_lock = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'd6, 3'd5, 8'd9, 8'd10);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("lock_clear", 32'({lock_err, ext_sel}), 0);
        repeat (S + 1) @(negedge clk);
`endif

        // Randomised traffic against the model
        for (int c = 0; c < 2000; c++) begin
            resetb = ($urandom_range(0, 199) != 0);
`ifdef DLL_LOCK_CHECK_EN
            dll_lock = ($urandom_range(0, 3) != 0);
`endif
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus($urandom_range(0, 2) != 0, 1'($urandom), m_sel, m_sel2, m_aux, m_prim);
            end else begin
                applyStimulus($urandom_range(0, 2) != 0, 1'($urandom), 3'($urandom), 3'($urandom),
                              8'($urandom_range(0, 3)), 8'($urandom));
            end
            @(negedge clk);
        end
        resetb = 1'b1;
        req_valid = 1'b0;
        repeat (3 * S + 2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
